// File: rtl/ifetch_align.sv
// Instruction fetch aligner: pulls whole words from instruction memory into a halfword
// queue and presents one aligned 16/32-bit instruction (or bus-error marker) at a time.
module ifetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_ready,
    input  logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_rresp,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    output logic        ins_compressed,
    output logic        ins_fault
);
    localparam int            IW        = $clog2(BUF_HW);
    localparam int            CW        = $clog2(BUF_HW + 1);
    localparam logic [CW-1:0] DEPTH     = CW'(BUF_HW);
    localparam logic [31:0]   RESET_HPC = RESET_PC & ~32'h1;

    typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_FAULT} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       fpc_q, fpc_d;
    logic [31:0]       pc_q, pc_d;
    logic [15:0]       hw_q [BUF_HW];
    logic [BUF_HW-1:0] flt_q;

    function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] base,
                                              input logic [CW-1:0] off);
        int unsigned s;
        s = 32'(base) + 32'(off);
        return IW'(s % BUF_HW);
    endfunction

    logic [IW-1:0] rd1, wr0, wr1;
    logic [15:0]   h0, h1;
    logic          f0, f1;
    logic [CW-1:0] pop_n, pop_act, push_n;
    logic          xfer;
    logic          we0, we1, wf0;
    logic [15:0]   wd0, wd1;

    assign rd1 = idx_add(rd_q, CW'(1));
    assign wr0 = idx_add(rd_q, cnt_q);
    assign wr1 = idx_add(rd_q, cnt_q + CW'(1));
    assign h0  = hw_q[rd_q];
    assign h1  = hw_q[rd1];
    assign f0  = flt_q[rd_q];
    assign f1  = flt_q[rd1];

    // fpc_q is the halfword PC of the next halfword to be fetched
    assign imem_addr  = fpc_q & ~32'h3;
    assign imem_ready = (state_q == ST_FETCH) && ((DEPTH - cnt_q) >= CW'(2));
    assign xfer       = imem_ready && imem_valid;
    assign ins_pc     = pc_q;

    // Head decode: everything here comes from registered queue state only
    always_comb begin
        ins_valid      = 1'b0;
        ins_data       = '0;
        ins_compressed = 1'b0;
        ins_fault      = 1'b0;
        pop_n          = '0;
        if (cnt_q != '0) begin
            if (f0) begin
                ins_valid = 1'b1;
                ins_fault = 1'b1;
                pop_n     = CW'(1);
            end else if (h0[1:0] != 2'b11) begin
                ins_valid      = 1'b1;
                ins_data       = {16'h0000, h0};
                ins_compressed = 1'b1;
                pop_n          = CW'(1);
            end else if (cnt_q >= CW'(2)) begin
                // a marker in the upper slot replaces the whole 32-bit instruction
                ins_valid = 1'b1;
                pop_n     = CW'(2);
                if (f1) begin
                    ins_fault = 1'b1;
                end else begin
                    ins_data = {h1, h0};
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        fpc_d   = fpc_q;
        pc_d    = pc_q;
        push_n  = '0;
        pop_act = '0;
        we0     = 1'b0;
        we1     = 1'b0;
        wf0     = 1'b0;
        wd0     = imem_rdata[15:0];
        wd1     = imem_rdata[31:16];
        if (redirect) begin
            state_d = ST_FETCH;
            rd_d    = '0;
            cnt_d   = '0;
            fpc_d   = redirect_pc & ~32'h1;
            pc_d    = redirect_pc & ~32'h1;
        end else begin
            if (state_q == ST_RESET) begin
                state_d = ST_FETCH;
            end
            if (xfer) begin
                if (!imem_rresp) begin
                    we0     = 1'b1;
                    wf0     = 1'b1;
                    push_n  = CW'(1);
                    state_d = ST_FAULT;
                end else if (fpc_q[1]) begin
                    // odd-halfword target: the low halfword precedes the target
                    we0    = 1'b1;
                    wd0    = imem_rdata[31:16];
                    push_n = CW'(1);
                    fpc_d  = fpc_q + 32'd2;
                end else begin
                    we0    = 1'b1;
                    we1    = 1'b1;
                    push_n = CW'(2);
                    fpc_d  = fpc_q + 32'd4;
                end
            end
            if (ins_valid && ins_ready) begin
                pop_act = pop_n;
            end
            cnt_d = cnt_q + push_n - pop_act;
            rd_d  = idx_add(rd_q, pop_act);
            pc_d  = pc_q + (32'(pop_act) << 1);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_RESET;
            rd_q    <= '0;
            cnt_q   <= '0;
            fpc_q   <= RESET_HPC;
            pc_q    <= RESET_HPC;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            fpc_q   <= fpc_d;
            pc_q    <= pc_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by cnt_q alone
    always_ff @(posedge clk) begin
        if (we0) begin
            hw_q[wr0]  <= wd0;
            flt_q[wr0] <= wf0;
        end
        if (we1) begin
            hw_q[wr1]  <= wd1;
            flt_q[wr1] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch_align.sv
// Self-checking bench for ifetch_align: directed scenarios plus randomized streams
// compared against an instruction-level model of the memory image.
module tb_ifetch_align;
    localparam int BUF_HW = 4;

    logic        clk = 1'b0;
    logic        resetb;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_rresp;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_compressed;
    logic        ins_fault;

    ifetch_align #(.RESET_PC(32'h0000_0000), .BUF_HW(BUF_HW)) dut (
        .clk(clk), .resetb(resetb), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_addr(imem_addr),
        .imem_rresp(imem_rresp), .imem_rdata(imem_rdata),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
        .ins_pc(ins_pc), .ins_compressed(ins_compressed), .ins_fault(ins_fault)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic        fault_en;
    logic [31:0] fault_addr;

    logic [31:0] got_data[$], got_pc[$], xfer_addr[$];
    logic        got_flt[$], got_cmp[$];
    logic [31:0] exp_data[$], exp_pc[$];
    logic        exp_flt[$], exp_cmp[$];
    int          n_chk = 0, n_pass = 0, n_xfer = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic is_fault(input logic [31:0] a);
        return fault_en && ((a & ~32'h3) == fault_addr);
    endfunction

    // Expected instruction stream straight from the memory image, halfword by halfword
    task automatic build_model(input logic [31:0] start, input int n);
        logic [31:0] pc;
        logic [15:0] h;
        exp_data.delete(); exp_pc.delete(); exp_flt.delete(); exp_cmp.delete();
        pc = start & ~32'h1;
        for (int i = 0; i < n; i++) begin
            h = half(pc);
            if (is_fault(pc) || (h[1:0] == 2'b11 && is_fault(pc + 32'd2))) begin
                exp_data.push_back(32'h0); exp_pc.push_back(pc);
                exp_flt.push_back(1'b1); exp_cmp.push_back(1'b0);
                break;
            end
            exp_pc.push_back(pc); exp_flt.push_back(1'b0);
            if (h[1:0] != 2'b11) begin
                exp_data.push_back({16'h0, h}); exp_cmp.push_back(1'b1);
                pc = pc + 32'd2;
            end else begin
                exp_data.push_back({half(pc + 32'd2), h}); exp_cmp.push_back(1'b0);
                pc = pc + 32'd4;
            end
        end
    endtask

    task automatic clear_got();
        got_data.delete(); got_pc.delete(); got_flt.delete(); got_cmp.delete();
        xfer_addr.delete();
        n_xfer = 0;
    endtask

    task automatic fill(input logic rnd);
        for (int i = 0; i < 256; i++) mem[i] = rnd ? $urandom : 32'h0000_0013;
        fault_en = 1'b0;
        fault_addr = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetb = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_valid = 1'b0; imem_rresp = 1'b1; imem_rdata = 32'h0; ins_ready = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        clear_got();
    endtask

    // One clock of memory/consumer stimulus; records handshakes, compares nothing
    task automatic cycle(input int p_mem, input int p_rdy, input logic redir,
                         input logic [31:0] rpc);
        @(negedge clk);
        redirect    = redir;
        redirect_pc = rpc;
        imem_valid  = ($urandom_range(99) < p_mem);
        imem_rdata  = mem_word(imem_addr);
        imem_rresp  = !is_fault(imem_addr);
        ins_ready   = ($urandom_range(99) < p_rdy);
        #1;
        if (imem_ready && imem_valid && !redir) begin
            n_xfer++;
            xfer_addr.push_back(imem_addr);
        end
        if (ins_valid && ins_ready && !redir) begin
            got_data.push_back(ins_data); got_pc.push_back(ins_pc);
            got_flt.push_back(ins_fault); got_cmp.push_back(ins_compressed);
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_valid = 1'b0;
        imem_rresp = 1'b1; imem_rdata = 32'h0; ins_ready = 1'b0;
        fill(1'b0);
        @(negedge clk); #1;
        n_chk++; if (imem_ready !== 1'b0) $display("FAIL reset imem_ready: got %b expected 0", imem_ready); else n_pass++;
        n_chk++; if (imem_addr !== 32'h0) $display("FAIL reset imem_addr: got %h expected 0", imem_addr); else n_pass++;
        n_chk++; if (ins_valid !== 1'b0) $display("FAIL reset ins_valid: got %b expected 0", ins_valid); else n_pass++;
        n_chk++; if (ins_data !== 32'h0) $display("FAIL reset ins_data: got %h expected 0", ins_data); else n_pass++;
        n_chk++; if (ins_pc !== 32'h0) $display("FAIL reset ins_pc: got %h expected 0", ins_pc); else n_pass++;
        n_chk++; if ({ins_compressed, ins_fault} !== 2'b00) $display("FAIL reset cmp/fault: got %b expected 00", {ins_compressed, ins_fault}); else n_pass++;
        @(negedge clk); resetb = 1'b1;
        @(negedge clk); #1;
        n_chk++; if (imem_ready !== 1'b1) $display("FAIL release imem_ready: got %b expected 1", imem_ready); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset(); fill(1'b0);
        mem[0] = 32'h0013_0093;
        for (int i = 0; i < 12; i++) cycle(100, 100, 1'b0, 32'h0);
        n_chk++; if (got_pc.size() < 2 || xfer_addr.size() < 1) $display("FAIL basic count: got %0d expected >=2", got_pc.size()); else n_pass++;
        if (got_pc.size() >= 2 && xfer_addr.size() >= 1) begin
            n_chk++; if (xfer_addr[0] !== 32'h0) $display("FAIL basic first addr: got %h expected 0", xfer_addr[0]); else n_pass++;
            n_chk++; if (got_data[0] !== 32'h0013_0093 || got_pc[0] !== 32'h0) $display("FAIL basic ins0: got %h@%h expected 00130093@0", got_data[0], got_pc[0]); else n_pass++;
            n_chk++; if (got_data[1] !== 32'h0000_0013 || got_pc[1] !== 32'h4) $display("FAIL basic ins1: got %h@%h expected 00000013@4", got_data[1], got_pc[1]); else n_pass++;
            n_chk++; if (got_cmp[0] !== 1'b0 || got_cmp[1] !== 1'b0) $display("FAIL basic compressed: got %b%b expected 00", got_cmp[0], got_cmp[1]); else n_pass++;
        end
    endtask

    task automatic test_compressed();
        do_reset(); fill(1'b0);
        mem[0] = 32'h4501_4505;
        for (int i = 0; i < 12; i++) cycle(100, 100, 1'b0, 32'h0);
        n_chk++; if (got_pc.size() < 3) $display("FAIL comp count: got %0d expected >=3", got_pc.size()); else n_pass++;
        if (got_pc.size() >= 3) begin
            n_chk++; if (got_data[0] !== 32'h4505 || got_pc[0] !== 32'h0 || got_cmp[0] !== 1'b1) $display("FAIL comp ins0: got %h@%h c=%b expected 00004505@0 c=1", got_data[0], got_pc[0], got_cmp[0]); else n_pass++;
            n_chk++; if (got_data[1] !== 32'h4501 || got_pc[1] !== 32'h2 || got_cmp[1] !== 1'b1) $display("FAIL comp ins1: got %h@%h c=%b expected 00004501@2 c=1", got_data[1], got_pc[1], got_cmp[1]); else n_pass++;
            n_chk++; if (got_data[2] !== 32'h13 || got_pc[2] !== 32'h4 || got_cmp[2] !== 1'b0) $display("FAIL comp ins2: got %h@%h c=%b expected 00000013@4 c=0", got_data[2], got_pc[2], got_cmp[2]); else n_pass++;
        end
    endtask

    task automatic test_straddle();
        do_reset(); fill(1'b0);
        mem[0] = 32'h0093_4505;
        mem[1] = 32'h0000_0001;
        for (int i = 0; i < 12; i++) cycle(100, 100, 1'b0, 32'h0);
        n_chk++; if (got_pc.size() < 2) $display("FAIL straddle count: got %0d expected >=2", got_pc.size()); else n_pass++;
        if (got_pc.size() >= 2) begin
            n_chk++; if (got_data[0] !== 32'h4505 || got_pc[0] !== 32'h0) $display("FAIL straddle ins0: got %h@%h expected 00004505@0", got_data[0], got_pc[0]); else n_pass++;
            n_chk++; if (got_data[1] !== 32'h0001_0093 || got_pc[1] !== 32'h2 || got_cmp[1] !== 1'b0) $display("FAIL straddle ins1: got %h@%h c=%b expected 00010093@2 c=0", got_data[1], got_pc[1], got_cmp[1]); else n_pass++;
        end
    endtask

    task automatic test_redirect();
        int cyc;
        do_reset(); fill(1'b1);
        for (int i = 0; i < 6; i++) cycle(100, 100, 1'b0, 32'h0);
        cycle(100, 100, 1'b1, 32'h0000_0102);
        clear_got();
        @(posedge clk); #1;
        n_chk++; if (ins_valid !== 1'b0) $display("FAIL redirect ins_valid: got %b expected 0", ins_valid); else n_pass++;
        n_chk++; if (imem_addr !== 32'h100) $display("FAIL redirect imem_addr: got %h expected 00000100", imem_addr); else n_pass++;
        n_chk++; if (ins_pc !== 32'h102) $display("FAIL redirect ins_pc: got %h expected 00000102", ins_pc); else n_pass++;
        build_model(32'h102, 12);
        cyc = 0;
        while (got_pc.size() < exp_pc.size() && cyc < 2000) begin cycle(100, 100, 1'b0, 32'h0); cyc++; end
        n_chk++; if (got_pc.size() < exp_pc.size()) $display("FAIL redirect timeout: got %0d expected %0d", got_pc.size(), exp_pc.size()); else n_pass++;
        for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
            n_chk++; if (got_pc[i] !== exp_pc[i]) $display("FAIL redirect pc[%0d]: got %h expected %h", i, got_pc[i], exp_pc[i]); else n_pass++;
            n_chk++; if (got_data[i] !== exp_data[i]) $display("FAIL redirect data[%0d]: got %h expected %h", i, got_data[i], exp_data[i]); else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] d0, p0;
        int cyc;
        do_reset(); fill(1'b1);
        for (int i = 0; i < 3; i++) cycle(100, 0, 1'b0, 32'h0);
        n_chk++; if (ins_valid !== 1'b1) $display("FAIL stall ins_valid: got %b expected 1", ins_valid); else n_pass++;
        d0 = ins_data; p0 = ins_pc;
        for (int i = 0; i < 10; i++) begin
            cycle(100, 0, 1'b0, 32'h0);
            n_chk++; if (ins_data !== d0 || ins_pc !== p0) $display("FAIL stall hold[%0d]: got %h@%h expected %h@%h", i, ins_data, ins_pc, d0, p0); else n_pass++;
        end
        n_chk++; if (imem_ready !== 1'b0) $display("FAIL stall imem_ready: got %b expected 0", imem_ready); else n_pass++;
        n_chk++; if (n_xfer != BUF_HW / 2) $display("FAIL stall fetches: got %0d expected %0d", n_xfer, BUF_HW / 2); else n_pass++;
        build_model(32'h0, 16);
        cyc = 0;
        while (got_pc.size() < exp_pc.size() && cyc < 2000) begin cycle(70, 100, 1'b0, 32'h0); cyc++; end
        n_chk++; if (got_pc.size() < exp_pc.size()) $display("FAIL stall timeout: got %0d expected %0d", got_pc.size(), exp_pc.size()); else n_pass++;
        for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
            n_chk++; if (got_pc[i] !== exp_pc[i] || got_data[i] !== exp_data[i]) $display("FAIL stall ins[%0d]: got %h@%h expected %h@%h", i, got_data[i], got_pc[i], exp_data[i], exp_pc[i]); else n_pass++;
        end
    endtask

    task automatic test_fault();
        do_reset(); fill(1'b0);
        fault_en = 1'b1; fault_addr = 32'h8;
        for (int i = 0; i < 20; i++) cycle(100, 100, 1'b0, 32'h0);
        n_chk++; if (got_pc.size() != 3) $display("FAIL fault count: got %0d expected 3", got_pc.size()); else n_pass++;
        if (got_pc.size() == 3) begin
            n_chk++; if (got_flt[0] !== 1'b0 || got_pc[1] !== 32'h4 || got_flt[1] !== 1'b0) $display("FAIL fault prior: got f=%b pc1=%h f=%b expected 0/4/0", got_flt[0], got_pc[1], got_flt[1]); else n_pass++;
            n_chk++; if (got_flt[2] !== 1'b1 || got_pc[2] !== 32'h8) $display("FAIL fault marker: got f=%b pc=%h expected 1@00000008", got_flt[2], got_pc[2]); else n_pass++;
        end
        n_chk++; if (imem_ready !== 1'b0 || ins_valid !== 1'b0) $display("FAIL fault idle: got ready=%b valid=%b expected 0 0", imem_ready, ins_valid); else n_pass++;
        fault_en = 1'b0;
        cycle(100, 100, 1'b1, 32'h0);
        clear_got();
        for (int i = 0; i < 10; i++) cycle(100, 100, 1'b0, 32'h0);
        n_chk++; if (got_pc.size() < 1 || got_pc[0] !== 32'h0 || got_flt[0] !== 1'b0) $display("FAIL fault resume: got n=%0d expected ins at 0 without fault", got_pc.size()); else n_pass++;
        // 32-bit instruction at pc 2 whose upper half lives in the faulting word
        do_reset(); fill(1'b0);
        mem[0] = 32'h0093_4505;
        fault_en = 1'b1; fault_addr = 32'h4;
        for (int i = 0; i < 20; i++) cycle(100, 100, 1'b0, 32'h0);
        n_chk++; if (got_pc.size() != 2) $display("FAIL sfault count: got %0d expected 2", got_pc.size()); else n_pass++;
        if (got_pc.size() == 2) begin
            n_chk++; if (got_data[0] !== 32'h4505 || got_flt[0] !== 1'b0) $display("FAIL sfault ins0: got %h f=%b expected 00004505 f=0", got_data[0], got_flt[0]); else n_pass++;
            n_chk++; if (got_flt[1] !== 1'b1 || got_pc[1] !== 32'h2) $display("FAIL sfault marker: got f=%b pc=%h expected 1@00000002", got_flt[1], got_pc[1]); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        do_reset(); fill(1'b1);
        for (int i = 0; i < 5; i++) cycle(100, 50, 1'b0, 32'h0);
        @(posedge clk); #2;
        resetb = 1'b0;
        #1;
        n_chk++; if (imem_ready !== 1'b0 || ins_valid !== 1'b0) $display("FAIL async reset: got ready=%b valid=%b expected 0 0", imem_ready, ins_valid); else n_pass++;
        n_chk++; if (imem_addr !== 32'h0 || ins_pc !== 32'h0) $display("FAIL async reset pc: got addr=%h pc=%h expected 0 0", imem_addr, ins_pc); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] target;
        int pm, pr, cyc;
        do_reset();
        for (int it = 0; it < 16; it++) begin
            fill(1'b1);
            target = (it == 0) ? 32'hFFFF_FFFB : $urandom;
            if ($urandom_range(2) == 0) begin
                fault_en = 1'b1;
                fault_addr = (target & ~32'h3) + 32'(4 * $urandom_range(6));
            end
            pm = $urandom_range(100, 30);
            pr = $urandom_range(100, 30);
            cycle(pm, pr, 1'b1, target);
            clear_got();
            build_model(target, 20);
            cyc = 0;
            while (got_pc.size() < exp_pc.size() && cyc < 2000) begin cycle(pm, pr, 1'b0, 32'h0); cyc++; end
            n_chk++; if (got_pc.size() < exp_pc.size()) $display("FAIL rnd%0d timeout: got %0d expected %0d", it, got_pc.size(), exp_pc.size()); else n_pass++;
            for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
                n_chk++; if (got_pc[i] !== exp_pc[i]) $display("FAIL rnd%0d pc[%0d]: got %h expected %h", it, i, got_pc[i], exp_pc[i]); else n_pass++;
                n_chk++; if (got_flt[i] !== exp_flt[i]) $display("FAIL rnd%0d fault[%0d]: got %b expected %b", it, i, got_flt[i], exp_flt[i]); else n_pass++;
                if (!exp_flt[i]) begin
                    n_chk++; if (got_data[i] !== exp_data[i]) $display("FAIL rnd%0d data[%0d]: got %h expected %h", it, i, got_data[i], exp_data[i]); else n_pass++;
                    n_chk++; if (got_cmp[i] !== exp_cmp[i]) $display("FAIL rnd%0d cmp[%0d]: got %b expected %b", it, i, got_cmp[i], exp_cmp[i]); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_compressed();
        test_straddle();
        test_redirect();
        test_stall();
        test_fault();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch_align.md
Name: ifetch_align

Overview:
- Fetch sequencer between the core's instruction port and the word-wide instruction RAM. Needed for C-extension support.
- Issues sequential word fetches on the imem handshake and buffers the returned halfwords.
- Emits one complete instruction per handshake, either 16-bit compressed or 32-bit, aligned to its own halfword PC, for the compressed decoder and pipeline.
- Handles PC redirects, odd-halfword targets, instructions straddling two words, and bus errors.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch PC after reset (bit 0 ignored).
- BUF_HW, 4, halfword buffer depth; legal values 4..8.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- redirect  in  1  flush buffer and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC, halfword aligned (bit 0 ignored)
- imem_ready  out  1  fetch request
- imem_valid  in  1  memory accepts request and returns data this cycle
- imem_addr  out  32  word address of request, bits[1:0]=0
- imem_rresp  in  1  1=OK, 0=bus error
- imem_rdata  in  32  fetched word, little-endian halfwords
- ins_valid  out  1  instruction available
- ins_ready  in  1  core accepts instruction
- ins_data  out  32  instruction; [31:16]=0 when compressed
- ins_pc  out  32  PC of ins_data
- ins_compressed  out  1  ins_data[1:0]!=2'b11
- ins_fault  out  1  entry is a bus-error marker

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (resetb).
- Reset values: imem_ready=0, imem_addr=RESET_PC&~3, ins_valid=0, ins_data=0, ins_pc=RESET_PC, ins_compressed=0, ins_fault=0. State=FETCH on the first clk edge after reset release.
- States:
  - FETCH: imem_ready=1 while free slots >= 2.
  - FAULT: imem_ready=0; hold the fault entry until it is consumed, then wait for redirect.
- Memory transfer:
  - A transfer completes on an edge where imem_ready&&imem_valid. imem_rdata and imem_rresp are sampled at that edge.
  - imem_addr and imem_ready must stay stable until the transfer completes.
  - Zero outstanding requests: no data ever arrives later.
- OK response:
  - Push the low halfword, then the high one; fetch PC += 4.
  - If it is the first word after a redirect or reset and the target PC[1]=1, drop the low halfword and push only the high one.
- Error response (rresp=0):
  - Push one fault marker carrying the faulting PC; go to FAULT.
  - Halfwords already buffered ahead of the marker drain normally.
- Head decode:
  - Head halfword [1:0]!=11 is compressed and needs 1 halfword.
  - Otherwise the instruction needs 2 halfwords.
  - ins_valid=1 when the required halfwords are present, or when the head is a fault marker.
  - A 32-bit instruction whose upper half is missing because of a fault is replaced by the fault marker: ins_fault=1, ins_pc = the instruction's PC.
- Output timing:
  - Outputs are driven from registers/buffer only, with no combinational path from ins_ready.
  - Outputs hold stable while ins_valid&&!ins_ready.
- Consume: on ins_valid&&ins_ready, pop 1 or 2 halfwords; ins_pc advances by 2 or 4.
- Full buffer (free slots < 2): imem_ready=0. Push and pop may happen in the same cycle; count += pushed - popped.
- Redirect:
  - Highest priority.
  - On that edge: clear the buffer, discard any same-cycle memory data, ignore any same-cycle consume, and set fetch PC = ins_pc = redirect_pc with bit 0 cleared.
  - Next state is FETCH from either state.
  - ins_valid=0 the cycle after.
- Address wrap: fetch PC wraps at 2^32 with no error.
- Reset mid-transfer: everything returns to the reset values immediately, asynchronously.

Test Plan:
- Reset release, memory always valid, words 0x00130093,0x00000013 -> first imem_addr=0x0; ins (0x00130093,pc 0x0), then (0x00000013,pc 0x4); ins_compressed=0.
- Word 0x45014505 then 0x00000013 -> ins 0x00004505 pc0 compressed, 0x00004501 pc2 compressed, 0x00000013 pc4.
- Straddle: word0=0x00934505, word1=0x00000001 -> 0x00004505 pc0, then 0x00010093 pc2 (32-bit, assembled across two words).
- redirect to 0x102 while instructions are buffered and ins_ready=1 -> buffer flushed; next imem_addr=0x100; first ins_pc=0x102 taken from the high halfword.
- ins_ready=0 for 10 cycles -> imem_ready drops once free slots < 2; ins_data stable; no overflow; order preserved after release.
- rresp=0 at addr 0x8 -> prior instructions delivered; then ins_fault=1 with ins_pc=0x8 (or the PC of the straddling instruction); imem_ready=0 until redirect.
